// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage request/response bundle between the pipeline and the HI/LO multiply/divide unit.
interface hilo_muldiv_ctrl_if;
  logic        valid_i;
  logic [4:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] hilo_rdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (output valid_i, op_i, a_i, b_i, flush_i,
                  input  stall_o, hilo_rdata_o, hi_o, lo_o);
  modport slave  (input  valid_i, op_i, a_i, b_i, flush_i,
                  output stall_o, hilo_rdata_o, hi_o, lo_o);
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative mult/div sequencer and HI/LO owner. Define HILO_FAST_MUL_EN to replace the
// 32-cycle shift-add multiply with a single registered '*' product (divide stays iterative).
module hilo_muldiv_ctrl (
  input  logic              clk,
  input  logic              rst,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam logic [4:0] OP_MFHI = 5'b11100;
  localparam logic [4:0] OP_MFLO = 5'b11110;
  localparam logic [4:0] OP_MTHI = 5'b11101;
  localparam logic [4:0] OP_MTLO = 5'b11111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] acc_q, acc_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        is_div_q, is_div_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_md, is_div_op, op_signed, launch;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] div_diff;
  logic [31:0] quo_fix, rem_fix;
  logic [63:0] prod_fix;

  assign is_md     = bus.op_i[4:2] == 3'b110;
  assign is_div_op = bus.op_i[1];
  assign op_signed = ~bus.op_i[0];
  assign launch    = bus.valid_i && is_md && !bus.flush_i;
  assign a_neg     = op_signed && bus.a_i[31];
  assign b_neg     = op_signed && bus.b_i[31];
  assign a_mag     = a_neg ? 32'd0 - bus.a_i : bus.a_i;
  assign b_mag     = b_neg ? 32'd0 - bus.b_i : bus.b_i;

  // acc holds {remainder, dividend/quotient}; bit 32 of the trial difference is the borrow.
  assign div_diff  = acc_q[63:31] - {1'b0, opb_q};

  assign quo_fix   = (sign_a_q ^ sign_b_q) ? 32'd0 - acc_q[31:0] : acc_q[31:0];
  assign rem_fix   = sign_a_q ? 32'd0 - acc_q[63:32] : acc_q[63:32];
  assign prod_fix  = (sign_a_q ^ sign_b_q) ? 64'd0 - acc_q : acc_q;

`ifndef HILO_FAST_MUL_EN
  logic [32:0] mul_sum;
  // acc holds {partial product, remaining multiplier bits}; add then shift right by one.
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
`endif

  always_comb begin
    // NOTE: every next-state signal is given its hold value first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (launch) begin
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          is_div_d = is_div_op;
          opa_d    = a_mag;
          opb_d    = b_mag;
          if (is_div_op && bus.b_i == 32'd0) begin
            // Divide by zero commits raw a_i / all-ones, so sign fixup is disabled.
            sign_a_d = 1'b0;
            sign_b_d = 1'b0;
            acc_d    = {bus.a_i, 32'hFFFF_FFFF};
            state_d  = DONE;
          end else begin
            acc_d    = {32'd0, is_div_op ? a_mag : b_mag};
            cnt_d    = 6'd32;
            state_d  = is_div_op ? DIV : MUL;
          end
        end else if (bus.valid_i) begin
          if (bus.op_i == OP_MTHI) hi_d = bus.a_i;
          if (bus.op_i == OP_MTLO) lo_d = bus.a_i;
        end
      end

      MUL: begin
`ifdef HILO_FAST_MUL_EN
        acc_d   = 64'(opa_q) * 64'(opb_q);
        cnt_d   = '0;
        state_d = DONE;
`else
        acc_d   = {mul_sum, acc_q[31:1]};
        cnt_d   = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = DONE;
`endif
      end

      DIV: begin
        acc_d = div_diff[32] ? {acc_q[62:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
        if (is_div_q) {hi_d, lo_d} = {rem_fix, quo_fix};
        else          {hi_d, lo_d} = prod_fix;
      end
    endcase

    // Flush wins over everything: abandon the operation and block any HI/LO write.
    if (bus.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.stall_o = !rst && ((state_q == IDLE && launch) ||
                                state_q == MUL || state_q == DIV);

  assign bus.hilo_rdata_o = (bus.op_i == OP_MFHI) ? hi_q :
                            (bus.op_i == OP_MFLO) ? lo_q : 32'd0;
  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer and HI/LO register owner for the execute stage. It takes the 5-bit ALU control codes for mult/multu/div/divu/mfhi/mflo/mthi/mtlo and runs an iterative signed or unsigned 32-bit divider and multiplier. It stalls the pipeline until the result is ready and commits the 64-bit result to HI/LO. It sits beside the ALU, and its `stall_o` feeds the hazard unit.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_i` in 1: an execute-stage instruction is present and not squashed.
- `op_i` in 5: ALU control code.
  - 11000 mult, 11001 multu, 11010 div, 11011 divu.
  - 11100 mfhi, 11110 mflo, 11101 mthi, 11111 mtlo.
  - Any other code is ignored.
- `a_i` in 32: rs operand (dividend / multiplicand / mthi-mtlo data).
- `b_i` in 32: rt operand (divisor / multiplier).
- `flush_i` in 1: cancel any in-flight operation (exception/eret).
- `stall_o` out 1: hold the execute stage and everything upstream.
- `hilo_rdata_o` out 32: HI for mfhi, LO for mflo, 0 otherwise. Combinational.
- `hi_o`, `lo_o` out 32 each: current HI/LO register values.

## Operation
- States: IDLE, MUL, DIV, DONE.
- A multi-cycle op is "md": mult, multu, div or divu.
- Launch: in IDLE with `valid_i` and md op and no `flush_i`:
  - latch `|a_i|`, `|b_i|` (signed ops) or raw values (unsigned ops);
  - latch sign flags and the op;
  - load a 6-bit counter with 32;
  - go to MUL or DIV.
- DIV: restoring radix-2 algorithm, one quotient bit per cycle. The counter decrements each cycle and the state moves to DONE when it reaches 0.
- Divisor zero: skip iteration and go IDLE→DONE directly. Result is LO=32'hFFFF_FFFF, HI=`a_i`.
- Signed division fixup, applied in DONE:
  - quotient is negated if the operand signs differ;
  - remainder takes the dividend's sign.
  - 0x8000_0000 / -1 gives LO=0x8000_0000, HI=0.
- MUL (default build): shift-add over 32 iterations on a 64-bit accumulator. Signed product is negated in DONE if the operand signs differ.
- DONE: `stall_o` is 0, so the held md instruction advances. HI (remainder / product[63:32]) and LO (quotient / product[31:0]) are written at the end of the DONE cycle; the state then returns to IDLE.
  - The md instruction still present on `valid_i` in DONE does not relaunch.
- mthi/mtlo: with `valid_i` in IDLE, HI/LO is written at the clock edge. No stall.
- mfhi/mflo: read the registers combinationally. There is no internal bypass; the mfhi/mflo timing is still correct because the commit happens before the dependent instruction reaches execute.
- `stall_o` = !`rst` && ((state==IDLE && `valid_i` && md && !`flush_i`) || state==MUL || state==DIV).
- `flush_i` in any state:
  - next state is IDLE and the counter is cleared;
  - no HI/LO write occurs that cycle, including in DONE, and mthi/mtlo are suppressed;
  - `stall_o` drops the following cycle.
- Reset: HI=0, LO=0, state IDLE, counter 0, accumulators 0, `stall_o`=0.
- Reset mid-operation abandons the operation with no HI/LO write.

## Timing
- Issue cycle T: `stall_o`=1 and operands are latched.
- Div/mult (default build):
  - T+1..T+32: MUL/DIV, `stall_o`=1.
  - T+33: DONE, `stall_o`=0.
  - HI/LO are visible from T+34.
  - Total stall is 33 cycles.
- Divide by zero: T issue, T+1 DONE, commit at the end of T+1.
- Multiply with `HILO_FAST_MUL_EN`: T issue, T+1 MUL, T+2 DONE.
- mthi/mtlo: the write takes effect at the end of cycle T, and an mfhi/mflo in T+1 returns the new value.
- Operands `a_i`/`b_i` are sampled only in the issue cycle. Later changes have no effect.

## Configuration
- `HILO_FAST_MUL_EN` defined:
  - multiply uses the synthesis `*` operator (DSP) on the latched operands;
  - the product is registered in the single MUL cycle;
  - stall is 2 cycles.
- `HILO_FAST_MUL_EN` undefined: iterative 32-cycle shift-add multiply, with the same 33-cycle stall as divide.
- Divide is always iterative.

## Test plan
- div, `a_i`=-7 (0xFFFF_FFF9), `b_i`=2 → `stall_o` high for exactly 33 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFD.
- divu, `a_i`=100, `b_i`=7 → HI=2, LO=14.
- multu 0xFFFF_FFFF × 0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001.
- mult -1 × 1 → HI=LO=0xFFFF_FFFF.
- Stall length: 33 cycles with the default build, 2 cycles with `HILO_FAST_MUL_EN`.
- div with `b_i`=0, `a_i`=0x1234 → stall exactly 1 cycle, then HI=0x1234, LO=0xFFFF_FFFF.
- Flush mid-operation: mthi 0xAAAA_AAAA, then div launched and `flush_i` pulsed at cycle T+10.
  - `stall_o`=0 at T+11 and HI remains 0xAAAA_AAAA.
  - A new div issued at T+12 completes normally.
- Reset mid-operation: `rst` asserted mid-divide → HI=LO=0 and `stall_o`=0 immediately. After release, a mtlo 0x5 in cycle T is returned by mflo in T+1 as 0x5.
